// File: rtl/noc_pkg.sv
// Shared NoC definitions: packetizer FSM states, router port indices and credit sizing.
package noc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } pkt_state_t;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int SOUTH = 2;
    localparam int EAST  = 3;
    localparam int WEST  = 4;

    // Bits needed to hold a credit count from 0 up to and including depth.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit pool for one downstream input buffer: starts full, saturates at DEPTH and
// flags a sticky error when a credit comes back that was never taken.
module noc_credit_counter #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             err
);

    localparam logic [WIDTH-1:0] FULL = WIDTH'(DEPTH);

    // A simultaneous return and spend cancel out, so overflow is only possible on a lone return.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= FULL;
            err   <= 1'b0;
        end else if (inc && !dec) begin
            if (count == FULL) begin
                err <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/axis_noc_packetizer.sv
// AXI-Stream to NoC flit injector with credit-based flow control.
// Optional AXIS_NOC_PACKETIZER_STATS_EN adds stat_flits / stat_stalls counters.
module axis_noc_packetizer
    import noc_pkg::*;
#(
    parameter int TDATA_WIDTH          = 64,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 2,
    parameter int SERIALIZATION_FACTOR = 2,
    parameter int FLIT_BUFFER_DEPTH    = 2,
    parameter int PACKET_MODE          = 1,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH,
    parameter int CREDIT_WIDTH         = credit_width(FLIT_BUFFER_DEPTH)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    input  logic                    axis_in_tvalid,
    output logic                    axis_in_tready,
    input  logic [TDATA_WIDTH-1:0]  axis_in_tdata,
    input  logic                    axis_in_tlast,
    input  logic [TID_WIDTH-1:0]    axis_in_tid,
    input  logic [TDEST_WIDTH-1:0]  axis_in_tdest,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credits_avail,
    output logic                    credit_err
`ifdef AXIS_NOC_PACKETIZER_STATS_EN
    ,
    output logic [31:0]             stat_flits,
    output logic [31:0]             stat_stalls
`endif
);

    localparam int IDX_W = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SERIALIZATION_FACTOR - 1);

    pkt_state_t state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [SERIALIZATION_FACTOR-1:0][FLIT_WIDTH-1:0] hold_flits;
    logic [DEST_WIDTH-1:0] hold_dest;
    logic hold_last;
    logic has_credit, last_flit, issue, accept;

    assign has_credit = (credits_avail != '0);
    assign last_flit  = (idx == LAST_IDX);
    assign issue      = (state == SEND) && has_credit;
    // A new beat may land in the same cycle the final flit of the current one leaves.
    assign axis_in_tready = !rst_noc_sync && ((state == IDLE) || (issue && last_flit));
    assign accept = axis_in_tvalid && axis_in_tready;

    noc_credit_counter #(
        .DEPTH (FLIT_BUFFER_DEPTH),
        .WIDTH (CREDIT_WIDTH)
    ) u_credits (
        .clk   (clk_noc),
        .rst   (rst_noc_sync),
        .inc   (credit_in),
        .dec   (issue),
        .count (credits_avail),
        .err   (credit_err)
    );

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SEND;
                    idx_next   = '0;
                end
            end
            SEND: begin
                if (issue) begin
                    if (last_flit) begin
                        idx_next   = '0;
                        state_next = accept ? SEND : IDLE;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state       <= IDLE;
            idx         <= '0;
            send_out    <= 1'b0;
            is_tail_out <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            send_out <= issue;
            if (issue) begin
                data_out    <= hold_flits[idx];
                dest_out    <= hold_dest;
                is_tail_out <= last_flit && ((PACKET_MODE == 0) || hold_last);
            end
        end
    end

    // Packed slicing puts flit 0 on the least significant bits of the beat.
    always_ff @(posedge clk_noc) begin
        if (accept) begin
            hold_flits <= axis_in_tdata;
            hold_dest  <= {axis_in_tid, axis_in_tdest};
            hold_last  <= axis_in_tlast;
        end
    end

`ifdef AXIS_NOC_PACKETIZER_STATS_EN
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            stat_flits  <= '0;
            stat_stalls <= '0;
        end else begin
            if (issue) begin
                stat_flits <= stat_flits + 32'd1;
            end
            if ((state == SEND) && !has_credit) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
